// File: rtl/sid_pkg.sv
// Shared types and constants for the SID waveform selector and its fade timer.
package sid;

    typedef logic [11:0] reg12_t;

    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    // One-hot SID cycle phase strobes; the selector updates on PHI2_PHI1.
    typedef logic [3:0] phase_t;
    localparam int unsigned PHI1_PHI2 = 0;
    localparam int unsigned PHI2      = 1;
    localparam int unsigned PHI2_PHI1 = 2;
    localparam int unsigned PHI1      = 3;

    // selector = {noise, pulse, saw, tri}
    typedef struct packed {
        logic [3:0]  selector;
        logic [7:0]  noise;
        logic        pulse;
        logic [11:0] saw_tri;
    } waveform_i_t;

    localparam logic [13:0] FADE_TTL_6581 = 14'd54;
    localparam logic [13:0] FADE_TTL_8580 = 14'd800;
    localparam logic [13:0] FADE_AGE_MAX  = 14'h3fff;

    function automatic logic [13:0] fade_ttl(input model_e m);
        return (m == MOS6581) ? FADE_TTL_6581 : FADE_TTL_8580;
    endfunction

endpackage

// File: rtl/sid_wave_fade.sv
// Millisecond age counter for the floating DAC input, with model-dependent expiry.
module sid_wave_fade
    import sid::*;
(
    input  logic   clk,
    input  logic   res_n,
    input  logic   tick_ms,
    input  model_e model,
    input  logic   clear,
    input  logic   run,
    output logic   expired
);

    logic [13:0] r_age;

    // clear outranks a coincident tick so age restarts at exactly 0
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_age <= '0;
        end else if (clear) begin
            r_age <= '0;
        end else if (tick_ms && run && (r_age != FADE_AGE_MAX)) begin
            r_age <= r_age + 14'd1;
        end
    end

    // >= lets a switch to the shorter TTL expire immediately
    assign expired = (r_age >= fade_ttl(model));

endmodule

// File: rtl/sid_waveform_select.sv
// Waveform selection/combination stage between the SID oscillator and the DAC.
module sid_waveform_select
    import sid::*;
(
    input  logic        clk,
    input  logic        res_n,
    input  logic        tick_ms,
    input  model_e      model,
    input  phase_t      phase,
    input  waveform_i_t wave_i,
    output reg12_t      wave_o,
    output logic [7:0]  noise_wb,
    output logic        noise_wb_en
);

    logic   w_strobe;
    logic   w_sel_zero;
    logic   w_expired;
    logic   w_wb_en;
    reg12_t w_comb;
    reg12_t w_wave_nxt;

    reg12_t     r_wave;
    logic [7:0] r_noise_wb;
    logic       r_noise_wb_en;
    logic       r_sel_zero;

    assign w_strobe   = phase[PHI2_PHI1];
    assign w_sel_zero = (wave_i.selector == 4'b0000);
    assign w_wb_en    = wave_i.selector[3] & (|wave_i.selector[2:0]);

    // All selected components are ANDed together, identical for both models
    always_comb begin
        w_comb = 12'hfff;
        if (wave_i.selector[0]) w_comb = w_comb & {wave_i.saw_tri[10:0], 1'b0};
        if (wave_i.selector[1]) w_comb = w_comb & wave_i.saw_tri;
        if (wave_i.selector[2]) w_comb = w_comb & {12{wave_i.pulse}};
        if (wave_i.selector[3]) w_comb = w_comb & {wave_i.noise, 4'b0000};
    end

    always_comb begin
        w_wave_nxt = r_wave;
        if (!w_sel_zero) begin
            w_wave_nxt = w_comb;
        end else if (w_expired) begin
            w_wave_nxt = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_wave        <= '0;
            r_noise_wb    <= '0;
            r_noise_wb_en <= 1'b0;
            r_sel_zero    <= 1'b0;
        end else if (w_strobe) begin
            r_wave        <= w_wave_nxt;
            r_noise_wb    <= w_wave_nxt[11:4];
            r_noise_wb_en <= w_wb_en;
            r_sel_zero    <= w_sel_zero;
        end
    end

    sid_wave_fade u_fade (
        .clk     (clk),
        .res_n   (res_n),
        .tick_ms (tick_ms),
        .model   (model),
        .clear   (w_strobe & ~w_sel_zero),
        .run     (r_sel_zero),
        .expired (w_expired)
    );

    assign wave_o      = r_wave;
    assign noise_wb    = r_noise_wb;
    assign noise_wb_en = r_noise_wb_en;

endmodule
